// File: rtl/green_tracker_pkg.sv
// Shared types and defaults for the green frame tracker.
// The tracker sequences one capture per camera frame and reports a bounding box.
package green_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam int H_PIX_DEF      = 320;
  localparam int V_LINES_DEF    = 240;
  localparam int MIN_PIXELS_DEF = 64;

  // Min trackers start at all-ones; users cast these to their coordinate width.
  localparam logic [31:0] XMIN_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] YMIN_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/green_frame_tracker_bbox_accum.sv
// Per-frame green pixel counter and bounding-box min/max trackers.
// The *_next outputs expose the values being written this cycle, so a load can include the current sample.
module bbox_accum
  import green_tracker_pkg::*;
#(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [CW-1:0] cnt_next,
  output logic [XW-1:0] xmin_next,
  output logic [XW-1:0] xmax_next,
  output logic [YW-1:0] ymin_next,
  output logic [YW-1:0] ymax_next
);

  localparam logic [XW-1:0] X_INIT  = XW'(XMIN_INIT);
  localparam logic [YW-1:0] Y_INIT  = YW'(YMIN_INIT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;

  always_comb begin
    cnt_d  = cnt_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (clr) begin
      cnt_d  = '0;
      xmin_d = X_INIT;
      xmax_d = '0;
      ymin_d = Y_INIT;
      ymax_d = '0;
    end else if (en) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      if (x < xmin_q) xmin_d = x;
      if (x > xmax_q) xmax_d = x;
      if (y < ymin_q) ymin_d = y;
      if (y > ymax_q) ymax_d = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      xmin_q <= X_INIT;
      xmax_q <= '0;
      ymin_q <= Y_INIT;
      ymax_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end

  assign cnt_next  = cnt_d;
  assign xmin_next = xmin_d;
  assign xmax_next = xmax_d;
  assign ymin_next = ymin_d;
  assign ymax_next = ymax_d;

endmodule

// File: rtl/green_frame_tracker.sv
// Frame-level controller for the green detector: gates pixel enables, tags results with x/y,
// and hands one bounding-box result per frame downstream.
module green_frame_tracker
  import green_tracker_pkg::*;
#(
  parameter int H_PIX      = H_PIX_DEF,
  parameter int V_LINES    = V_LINES_DEF,
  parameter int MIN_PIXELS = MIN_PIXELS_DEF,
  parameter int XW         = 9,
  parameter int YW         = 8,
  parameter int CW         = 17
) (
  input  logic          PCLK,
  input  logic          rst_n,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic          e_pix,
  input  logic          eh_verde,
  input  logic          start,
  input  logic          continuous,
  output logic          det_e_pix,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic          res_found,
  output logic [XW-1:0] res_xmin,
  output logic [XW-1:0] res_xmax,
  output logic [YW-1:0] res_ymin,
  output logic [YW-1:0] res_ymax,
  output logic [XW-1:0] res_xc,
  output logic [YW-1:0] res_yc,
  output logic [7:0]    frames_dropped,
  output state_t        dbg_state
);

  localparam logic [XW-1:0] X_LAST  = XW'(H_PIX - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_LINES - 1);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

  state_t        state_q, state_d;
  logic          vsync_q, href_q;
  logic [XW-1:0] x_q, x_d, x_dly_q;
  logic [YW-1:0] y_q, y_d, y_dly_q;
  logic          det_dly_q;
  logic          res_valid_q, res_valid_d;
  logic [CW-1:0] res_count_q, res_count_d;
  logic          res_found_q, res_found_d;
  logic [XW-1:0] res_xmin_q, res_xmin_d, res_xmax_q, res_xmax_d, res_xc_q, res_xc_d;
  logic [YW-1:0] res_ymin_q, res_ymin_d, res_ymax_q, res_ymax_d, res_yc_q, res_yc_d;
  logic [7:0]    dropped_q, dropped_d;

  logic          vs_fall, vs_rise, href_fall, handshake;
  logic          acc_clr, acc_en;
  logic [CW-1:0] cnt_next;
  logic [XW-1:0] xmin_next, xmax_next;
  logic [YW-1:0] ymin_next, ymax_next;
  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;

  assign vs_fall   = vsync_q && !VSYNC;
  assign vs_rise   = !vsync_q && VSYNC;
  assign href_fall = href_q && !HREF;
  assign det_e_pix = e_pix && HREF && (state_q == CAPTURE);

  // Result handshake: res_valid holds with all res_* stable until a cycle where
  // res_valid && res_ready are both high; that cycle transfers the result.
  assign handshake = res_valid_q && res_ready;

  // eh_verde arrives one PCLK after its e_pix, so pair it with the delayed strobe/coordinates.
  assign acc_clr = (state_q == WAIT_VS) && vs_fall;
  assign acc_en  = det_dly_q && eh_verde;

  bbox_accum #(.XW(XW), .YW(YW), .CW(CW)) u_accum (
    .clk       (PCLK),
    .rst_n     (rst_n),
    .clr       (acc_clr),
    .en        (acc_en),
    .x         (x_dly_q),
    .y         (y_dly_q),
    .cnt_next  (cnt_next),
    .xmin_next (xmin_next),
    .xmax_next (xmax_next),
    .ymin_next (ymin_next),
    .ymax_next (ymax_next)
  );

  assign x_sum = {1'b0, xmin_next} + {1'b0, xmax_next};
  assign y_sum = {1'b0, ymin_next} + {1'b0, ymax_next};

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    res_valid_d = res_valid_q;
    res_count_d = res_count_q;
    res_found_d = res_found_q;
    res_xmin_d  = res_xmin_q;
    res_xmax_d  = res_xmax_q;
    res_ymin_d  = res_ymin_q;
    res_ymax_d  = res_ymax_q;
    res_xc_d    = res_xc_q;
    res_yc_d    = res_yc_q;
    dropped_d   = dropped_q;

    if (href_fall) x_d = '0;
    else if (det_e_pix && (x_q != X_LAST)) x_d = x_q + XW'(1);

    case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_fall) begin
          state_d = CAPTURE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      CAPTURE: begin
        if (href_fall && (y_q != Y_LAST)) y_d = y_q + YW'(1);
        if (vs_rise) begin
          state_d     = REPORT;
          res_valid_d = 1'b1;
          res_count_d = cnt_next;
          res_found_d = (cnt_next >= MIN_CNT);
          // An empty frame reports a zero box instead of the all-ones min initialisers.
          if (cnt_next == '0) begin
            res_xmin_d = '0;
            res_xmax_d = '0;
            res_ymin_d = '0;
            res_ymax_d = '0;
            res_xc_d   = '0;
            res_yc_d   = '0;
          end else begin
            res_xmin_d = xmin_next;
            res_xmax_d = xmax_next;
            res_ymin_d = ymin_next;
            res_ymax_d = ymax_next;
            res_xc_d   = x_sum[XW:1];
            res_yc_d   = y_sum[YW:1];
          end
        end
      end
      REPORT: begin
        if (handshake) begin
          res_valid_d = 1'b0;
          state_d     = continuous ? WAIT_VS : IDLE;
        end else if (vs_fall && continuous && (dropped_q != 8'hFF)) begin
          dropped_d = dropped_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      x_dly_q     <= '0;
      y_dly_q     <= '0;
      det_dly_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_found_q <= 1'b0;
      res_xmin_q  <= '0;
      res_xmax_q  <= '0;
      res_ymin_q  <= '0;
      res_ymax_q  <= '0;
      res_xc_q    <= '0;
      res_yc_q    <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= VSYNC;
      href_q      <= HREF;
      x_q         <= x_d;
      y_q         <= y_d;
      x_dly_q     <= x_q;
      y_dly_q     <= y_q;
      det_dly_q   <= det_e_pix;
      res_valid_q <= res_valid_d;
      res_count_q <= res_count_d;
      res_found_q <= res_found_d;
      res_xmin_q  <= res_xmin_d;
      res_xmax_q  <= res_xmax_d;
      res_ymin_q  <= res_ymin_d;
      res_ymax_q  <= res_ymax_d;
      res_xc_q    <= res_xc_d;
      res_yc_q    <= res_yc_d;
      dropped_q   <= dropped_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign res_valid      = res_valid_q;
  assign res_count      = res_count_q;
  assign res_found      = res_found_q;
  assign res_xmin       = res_xmin_q;
  assign res_xmax       = res_xmax_q;
  assign res_ymin       = res_ymin_q;
  assign res_ymax       = res_ymax_q;
  assign res_xc         = res_xc_q;
  assign res_yc         = res_yc_q;
  assign frames_dropped = dropped_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_green_frame_tracker.sv
// Directed bench for green_frame_tracker: drives short synthetic frames and checks each report.
module tb_green_frame_tracker;
  import green_tracker_pkg::*;

  logic        PCLK;
  logic        rst_n;
  logic        VSYNC, HREF, e_pix, eh_verde, start, continuous, res_ready;
  logic        det_e_pix, busy, res_valid, res_found;
  logic [16:0] res_count;
  logic [8:0]  res_xmin, res_xmax, res_xc;
  logic [7:0]  res_ymin, res_ymax, res_yc;
  logic [7:0]  frames_dropped;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  green_frame_tracker dut (
    .PCLK           (PCLK),
    .rst_n          (rst_n),
    .VSYNC          (VSYNC),
    .HREF           (HREF),
    .e_pix          (e_pix),
    .eh_verde       (eh_verde),
    .start          (start),
    .continuous     (continuous),
    .det_e_pix      (det_e_pix),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_count      (res_count),
    .res_found      (res_found),
    .res_xmin       (res_xmin),
    .res_xmax       (res_xmax),
    .res_ymin       (res_ymin),
    .res_ymax       (res_ymax),
    .res_xc         (res_xc),
    .res_yc         (res_yc),
    .frames_dropped (frames_dropped),
    .dbg_state      (dbg_state)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input int cnt, input int xmin, input int xmax,
                           input int ymin, input int ymax, input int xc, input int yc,
                           input int found);
    check({tag, ".valid"}, 32'(res_valid), 32'd1);
    check({tag, ".count"}, 32'(res_count), cnt);
    check({tag, ".xmin"},  32'(res_xmin),  xmin);
    check({tag, ".xmax"},  32'(res_xmax),  xmax);
    check({tag, ".ymin"},  32'(res_ymin),  ymin);
    check({tag, ".ymax"},  32'(res_ymax),  ymax);
    check({tag, ".xc"},    32'(res_xc),    xc);
    check({tag, ".yc"},    32'(res_yc),    yc);
    check({tag, ".found"}, 32'(res_found), found);
  endtask

  // Green pixel patterns: 0 none, 1 single at (10,5), 2 square 100..131 x 50..81, 3 column x=0.
  function automatic logic green(input int x, input int y, input int mode);
    case (mode)
      1:       return (x == 10) && (y == 5);
      2:       return (x >= 100) && (x <= 131) && (y >= 50) && (y <= 81);
      3:       return (x == 0);
      default: return 1'b0;
    endcase
  endfunction

  // One frame: VSYNC falls, n lines of p pixel strobes, VSYNC rises.
  // eh_verde follows the strobe by 'lag' cycles; start pulses at line start_line if >= 0.
  task automatic run_frame(input int p, input int n, input int mode, input int lag,
                           input int start_line);
    VSYNC = 1'b0;
    repeat (3) step();
    for (int ln = 0; ln < n; ln++) begin
      HREF = 1'b1;
      for (int c = 0; c < p + 2; c++) begin
        start    = (ln == start_line) && (c == 0);
        e_pix    = (c < p);
        eh_verde = (c - lag >= 0 && c - lag < p) ? green(c - lag, ln, mode) : 1'b0;
        step();
      end
      start    = 1'b0;
      HREF     = 1'b0;
      e_pix    = 1'b0;
      eh_verde = 1'b0;
      step();
      step();
    end
    VSYNC = 1'b1;
    repeat (3) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    VSYNC      = 1'b1;
    HREF       = 1'b0;
    e_pix      = 1'b0;
    eh_verde   = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    res_ready  = 1'b0;
    repeat (3) step();

    check("rst.valid",   32'(res_valid),      32'd0);
    check("rst.busy",    32'(busy),           32'd0);
    check("rst.count",   32'(res_count),      32'd0);
    check("rst.xmin",    32'(res_xmin),       32'd0);
    check("rst.ymin",    32'(res_ymin),       32'd0);
    check("rst.dropped", 32'(frames_dropped), 32'd0);
    check("rst.state",   32'(dbg_state),      32'(IDLE));
    rst_n = 1'b1;
    step();

    HREF  = 1'b1;
    e_pix = 1'b1;
    #1;
    check("idle.det_e_pix", 32'(det_e_pix), 32'd0);
    HREF  = 1'b0;
    e_pix = 1'b0;
    step();

    pulse_start();
    check("single.busy",  32'(busy),      32'd1);
    check("single.state", 32'(dbg_state), 32'(WAIT_VS));
    run_frame(16, 8, 1, 1, -1);
    check("single.rstate", 32'(dbg_state), 32'(REPORT));
    check_res("single", 1, 10, 10, 5, 5, 10, 5, 0);
    handshake();
    check("single.valid_drop", 32'(res_valid), 32'd0);
    check("single.idle",       32'(dbg_state), 32'(IDLE));

    pulse_start();
    run_frame(140, 90, 2, 1, -1);
    check_res("square", 1024, 100, 131, 50, 81, 115, 65, 1);
    handshake();

    pulse_start();
    run_frame(8, 4, 0, 1, -1);
    check_res("empty", 0, 0, 0, 0, 0, 0, 0, 0);
    handshake();

    pulse_start();
    run_frame(4, 240, 3, 1, -1);
    check_res("pipe_lag1", 240, 0, 0, 0, 239, 0, 119, 1);
    handshake();

    pulse_start();
    run_frame(4, 240, 3, 2, -1);
    check_res("pipe_lag2", 240, 1, 1, 0, 239, 1, 119, 1);
    handshake();

    continuous = 1'b1;
    pulse_start();
    run_frame(16, 8, 1, 1, -1);
    check_res("cont.f1", 1, 10, 10, 5, 5, 10, 5, 0);
    run_frame(8, 4, 3, 1, -1);
    check("cont.dropped1", 32'(frames_dropped), 32'd1);
    check("cont.hold1",    32'(res_count),      32'd1);
    run_frame(8, 4, 3, 1, -1);
    check("cont.dropped2", 32'(frames_dropped), 32'd2);
    check_res("cont.hold2", 1, 10, 10, 5, 5, 10, 5, 0);
    handshake();
    check("cont.valid_drop", 32'(res_valid),      32'd0);
    check("cont.rearm",      32'(dbg_state),      32'(WAIT_VS));
    check("cont.dropped3",   32'(frames_dropped), 32'd2);
    run_frame(4, 3, 3, 1, -1);
    check_res("cont.f4", 3, 0, 0, 0, 2, 0, 1, 0);
    check("cont.dropped4", 32'(frames_dropped), 32'd2);
    continuous = 1'b0;
    handshake();
    check("cont.idle", 32'(dbg_state), 32'(IDLE));

    pulse_start();
    VSYNC = 1'b0;
    repeat (3) step();
    HREF     = 1'b1;
    e_pix    = 1'b1;
    eh_verde = 1'b1;
    repeat (3) step();
    check("midrst.capture", 32'(dbg_state), 32'(CAPTURE));
    check("midrst.det",     32'(det_e_pix), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.state",   32'(dbg_state),      32'(IDLE));
    check("midrst.busy",    32'(busy),           32'd0);
    check("midrst.valid",   32'(res_valid),      32'd0);
    check("midrst.count",   32'(res_count),      32'd0);
    check("midrst.ymax",    32'(res_ymax),       32'd0);
    check("midrst.yc",      32'(res_yc),         32'd0);
    check("midrst.dropped", 32'(frames_dropped), 32'd0);
    check("midrst.det0",    32'(det_e_pix),      32'd0);
    HREF     = 1'b0;
    e_pix    = 1'b0;
    eh_verde = 1'b0;
    VSYNC    = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();

    run_frame(16, 8, 1, 1, -1);
    check("nostart.valid", 32'(res_valid), 32'd0);
    check("nostart.busy",  32'(busy),      32'd0);

    pulse_start();
    run_frame(16, 8, 1, 1, 3);
    check_res("busystart", 1, 10, 10, 5, 5, 10, 5, 0);
    handshake();
    check("busystart.idle", 32'(dbg_state), 32'(IDLE));
    run_frame(16, 8, 1, 1, -1);
    check("busystart.noextra", 32'(res_valid), 32'd0);
    check("busystart.state",   32'(dbg_state), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/green_frame_tracker.md
Name: green_frame_tracker

Overview:
- Frame-level controller for the per-pixel green detector.
- Gates the detector's pixel enable and sequences capture on camera frame boundaries (VSYNC/HREF).
- Tags each registered eh_verde result with its x/y coordinate and accumulates green count plus bounding box per frame.
- Presents one result per frame to the downstream game/overlay logic via a valid/ready handshake.

Parameters:
H_PIX, 320, pixel groups (e_pix pulses) per active line
V_LINES, 240, active lines per frame
MIN_PIXELS, 64, minimum green count for res_found=1
XW, 9, x coordinate width
YW, 8, y coordinate width
CW, 17, green counter width

Ports:
PCLK  in  1  pixel clock, sole clock
rst_n  in  1  asynchronous active-low reset
VSYNC  in  1  camera vsync, high = vertical blanking
HREF  in  1  camera href, high = active line
e_pix  in  1  pixel-group strobe from capture logic
eh_verde  in  1  detector output, registered one PCLK after its e_pix
start  in  1  single-cycle pulse arming capture
continuous  in  1  1 = re-arm automatically after each report
det_e_pix  out  1  gated e_pix to the detector
busy  out  1  state != IDLE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_count  out  CW  green pixels in frame
res_found  out  1  res_count >= MIN_PIXELS
res_xmin, res_xmax  out  XW  bounding box x
res_ymin, res_ymax  out  YW  bounding box y
res_xc  out  XW  (xmin+xmax)>>1
res_yc  out  YW  (ymin+ymax)>>1
frames_dropped  out  8  frames skipped while result pending, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; xmin/ymin accumulators = all-ones; xmax/ymax = 0; x = 0; y = 0.
- FSM states: IDLE, WAIT_VS, CAPTURE, REPORT.
  - IDLE: start -> WAIT_VS.
  - WAIT_VS: VSYNC falling edge -> CAPTURE. Accumulators are cleared in the same cycle.
  - CAPTURE: next VSYNC rising edge -> REPORT. Result registers are loaded on that edge and res_valid=1 the following cycle.
  - REPORT: on res_valid&&res_ready, go to WAIT_VS if continuous, else IDLE; res_valid drops the next cycle.
- Edge detection uses one-cycle delayed copies of VSYNC and HREF. Camera inputs are treated as PCLK-synchronous; no synchronisers.
- det_e_pix = e_pix && HREF && state==CAPTURE (combinational).
- Coordinates:
  - x increments on each det_e_pix and resets to 0 on HREF falling.
  - y increments on HREF falling in CAPTURE and resets to 0 on entry to CAPTURE.
  - x saturates at H_PIX-1; y saturates at V_LINES-1.
- Pipeline: x, y and det_e_pix are delayed by one stage so that eh_verde is paired with the coordinate of the e_pix that produced it. The accumulation condition is det_e_pix_d && eh_verde.
- The delayed sample that coincides with the VSYNC rising edge is still accumulated before the load.
- Accumulation per green pixel:
  - count += 1, saturating at 2^CW-1.
  - xmin = min(xmin, x_d); xmax = max(xmax, x_d); ymin and ymax likewise.
- Zero green pixels: res_count=0, res_found=0, and all bbox/centre outputs forced to 0.
- Centres are computed with an XW+1 / YW+1 bit sum, then shifted right by 1.
- All res_* outputs stay stable while res_valid=1.
- continuous=1 while REPORT is still pending at a VSYNC falling edge:
  - that frame is skipped and frames_dropped increments, saturating at 255;
  - capture resumes at the first VSYNC falling edge after the handshake.
- frames_dropped clears only on reset.
- start is ignored while busy.
- continuous is sampled only at handshake time.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values. After release, no capture occurs until start, then the next full frame.

Decomposition:
- Package green_tracker_pkg holds:
  - the state enum;
  - default H_PIX/V_LINES/MIN_PIXELS;
  - the helper constants XMIN_INIT/YMIN_INIT (all-ones).
- One sub-module, bbox_accum: count, min/max registers, saturation, clear/enable inputs. Instantiated once.
- FSM, coordinate counters, pipeline stage and result handshake stay in the top level.

Test Plan:
- Single green pixel: green at x=10,y=5, start, one frame -> res_count=1, bbox (10,10,5,5), res_xc=10, res_found=0.
- Square block: green square x 100..131, y 50..81 (1024 px) -> res_count=1024, bbox (100,131,50,81), xc=115, yc=65, res_found=1.
- No green: full frame with eh_verde=0 -> res_valid=1, count=0, all bbox/centre outputs 0, found=0.
- Pipeline alignment: eh_verde=1 exactly one cycle after e_pix at x=0 only, on every line -> xmin=xmax=0, count=240. Shifting eh_verde by one extra cycle must change the result (guards off-by-one).
- Continuous with blocked consumer: continuous=1, res_ready=0 across 3 frames, then ready=1 -> exactly one handshake, frames_dropped=2 (frames 2 and 3), next frame reported normally.
- Reset and start filtering: rst_n low mid-CAPTURE -> all outputs 0, state IDLE; start pulsed during CAPTURE -> no extra report; det_e_pix=0 in IDLE even with e_pix=1.
